rect_flip_engine: RTL and testbench
===================================

Name: rect_flip_engine

Overview:
Stateful, parametrised successor to the rectangle-corner flip logic in the Rectangle Loop datapath. Holds a ROWS x COLS bit matrix in a register, accepts rectangle commands through a valid/ready handshake and applies them to the held matrix. Supports three modes: corner flip (single cycle), perimeter flip and fill flip (both multi-cycle, one row per cycle). Sits between the loop-search controller, which issues commands, and downstream matrix consumers, which read m_out.

Parameters:
ROWS, 4, matrix row count (>=1)
COLS, 4, matrix column count (>=1)
RW, (ROWS>1 ? $clog2(ROWS) : 1), row coordinate width (derived localparam)
CW, (COLS>1 ? $clog2(COLS) : 1), column coordinate width (derived localparam)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
load_valid  in  1  load load_data into matrix (accepted only in IDLE)
load_data  in  ROWS*COLS  matrix image; bit (ROWS*COLS-1)-(r*COLS+c) = cell (r,c)
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command this cycle
cmd_op  in  2  00 CORNER, 01 PERIMETER, 10 FILL, 11 reserved
cmd_r1, cmd_r2  in  RW  rectangle rows (any order)
cmd_c1, cmd_c2  in  CW  rectangle columns (any order)
m_out  out  ROWS*COLS  registered matrix contents
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse: command finished, m_out final
err  out  1  one-cycle pulse: command rejected, matrix unchanged
ones_count  out  $clog2(ROWS*COLS+1)  popcount of matrix (see Optional Feature)

Behaviour:
- Reset (sync, active-high, priority over everything): m_out=0, state IDLE, busy=0, done=0, err=0, ones_count=0. Reset mid-operation abandons the op with no done/err.
- Bit mapping as for load_data; cell (0,0) is the MSB.
- cmd_ready = (state==IDLE) && !load_valid. Load has priority over commands in IDLE; load_valid outside IDLE is ignored. Load: m_out<=load_data at the next edge, no done.
- Accept = cmd_valid && cmd_ready at an edge. Coordinates are normalised on accept: r_lo=min(r1,r2), r_hi=max(r1,r2), c_lo/c_hi likewise.
- Reject if op==11 or any coordinate >= ROWS/COLS: err=1 in the next cycle, state stays IDLE, matrix unchanged, no done.
- CORNER: mask = OR of the four corner one-hot bits, so coincident corners flip once. m_out<=m_out^mask at the accept edge. done=1 in the following cycle; busy stays 0.
- PERIMETER/FILL: FSM IDLE->ROW; row pointer starts at r_lo.
  - Each ROW cycle XORs a per-row mask into m_out.
  - FILL row mask: columns c_lo..c_hi.
  - PERIMETER row mask: columns c_lo..c_hi when the row is r_lo or r_hi; otherwise only columns c_lo and c_hi (a single bit when c_lo==c_hi).
  - After processing row r_hi: ROW->IDLE, and done=1 in the cycle where m_out holds the final value.
  - busy=1 exactly while in ROW. Total latency is r_hi-r_lo+1 cycles from accept to done.
- Commands presented while busy are stalled (cmd_ready=0); held stimulus must not be consumed twice.
- done and err are never asserted in the same cycle.

Optional Feature:
FLIP_POPCOUNT_EN: when defined, ones_count is a registered popcount of m_out, lagging m_out by one cycle (reset 0). When undefined, ones_count is tied to 0 and no popcount logic is synthesised.

Test Plan:
- 4x4, reset, CORNER r=1,2 c=1,2 -> next cycle m_out=16'h0660, done=1 for 1 cycle, busy never 1.
- 4x4, m_out=0, PERIMETER r=3,0 c=0,3 -> busy for 4 cycles, then m_out=16'hF99F and done once; cmd_ready=0 throughout.
- 4x4, load 16'hFFFF then FILL r=1,2 c=0,3 -> 2 cycles later m_out=16'hF00F, done once.
- 4x4, m_out=0, CORNER r1=r2=1 c1=c2=1 -> m_out=16'h0400; then PERIMETER r=1,1 c=1,2 -> m_out=16'h0200.
- ROWS=3 COLS=5, CMD r1=3 -> err pulse, m_out unchanged; then cmd_op=11 -> err pulse; load_valid and cmd_valid asserted together in IDLE -> load wins and the command is accepted on the next cycle.
- Assert rst during the 2nd ROW cycle of a 4-row FILL -> next cycle m_out=0, busy=0, no done; with FLIP_POPCOUNT_EN, 16'hF99F loaded -> ones_count=12 one cycle after m_out updates.

Source files
------------

// File: rtl/rect_flip_engine.sv
// rect_flip_engine: register-held ROWS x COLS bit matrix updated by corner/perimeter/fill rectangle flips.
// Optional build macro FLIP_POPCOUNT_EN adds a registered popcount of the matrix on ones_count.
module rect_flip_engine #(
  parameter  int ROWS = 4,
  parameter  int COLS = 4,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int N    = ROWS * COLS,
  localparam int PW   = $clog2(ROWS * COLS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [N-1:0]  load_data,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [RW-1:0] cmd_r1,
  input  logic [RW-1:0] cmd_r2,
  input  logic [CW-1:0] cmd_c1,
  input  logic [CW-1:0] cmd_c2,
  output logic [N-1:0]  m_out,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [PW-1:0] ones_count
);

  typedef enum logic [1:0] {
    OP_CORNER    = 2'b00,
    OP_PERIMETER = 2'b01,
    OP_FILL      = 2'b10,
    OP_RSVD      = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_ROW
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  m_q;
  logic [RW-1:0] row_q, r_lo_q, r_hi_q;
  logic [CW-1:0] c_lo_q, c_hi_q;
  logic          fill_q;
  logic          done_q, err_q;

  op_e           op;
  logic          accept, bad_cmd, start_multi, last_row, edge_row;
  logic [RW-1:0] r_lo, r_hi;
  logic [CW-1:0] c_lo, c_hi;
  logic [N-1:0]  corner_mask, row_mask;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q == S_IDLE) && !load_valid;
  assign accept    = cmd_valid && cmd_ready;

  assign r_lo = (cmd_r1 < cmd_r2) ? cmd_r1 : cmd_r2;
  assign r_hi = (cmd_r1 < cmd_r2) ? cmd_r2 : cmd_r1;
  assign c_lo = (cmd_c1 < cmd_c2) ? cmd_c1 : cmd_c2;
  assign c_hi = (cmd_c1 < cmd_c2) ? cmd_c2 : cmd_c1;

  // Coordinate ports may be wider than the matrix (non power-of-two sizes), so range-check them.
  assign bad_cmd = (op == OP_RSVD)
                || (int'(cmd_r1) >= ROWS) || (int'(cmd_r2) >= ROWS)
                || (int'(cmd_c1) >= COLS) || (int'(cmd_c2) >= COLS);

  assign start_multi = accept && !bad_cmd && (op != OP_CORNER);
  assign last_row    = (row_q == r_hi_q);
  assign edge_row    = (row_q == r_lo_q) || (row_q == r_hi_q);

  // Corner cells are ORed so coincident corners flip only once.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
    corner_mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((r == int'(cmd_r1) || r == int'(cmd_r2)) &&
            (c == int'(cmd_c1) || c == int'(cmd_c2)))
          corner_mask[N-1-(r*COLS+c)] = 1'b1;
      end
    end
  end

  always_comb begin
    row_mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r == int'(row_q)) begin
          if (fill_q || edge_row) begin
            if (c >= int'(c_lo_q) && c <= int'(c_hi_q))
              row_mask[N-1-(r*COLS+c)] = 1'b1;
          end else if (c == int'(c_lo_q) || c == int'(c_hi_q)) begin
            row_mask[N-1-(r*COLS+c)] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_multi) state_d = S_ROW;
      S_ROW:   if (last_row)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= '0;
      row_q  <= '0;
      r_lo_q <= '0;
      r_hi_q <= '0;
      c_lo_q <= '0;
      c_hi_q <= '0;
      fill_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            m_q <= load_data;
          end else if (accept) begin
            if (bad_cmd) begin
              err_q <= 1'b1;
            end else if (op == OP_CORNER) begin
              m_q    <= m_q ^ corner_mask;
              done_q <= 1'b1;
            end else begin
              row_q  <= r_lo;
              r_lo_q <= r_lo;
              r_hi_q <= r_hi;
              c_lo_q <= c_lo;
              c_hi_q <= c_hi;
              fill_q <= (op == OP_FILL);
            end
          end
        end
        S_ROW: begin
          m_q   <= m_q ^ row_mask;
          row_q <= row_q + RW'(1);
          if (last_row) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m_out = m_q;
  assign busy  = (state_q == S_ROW);
  assign done  = done_q;
  assign err   = err_q;

`ifdef FLIP_POPCOUNT_EN
  logic [PW-1:0] pop_d, pop_q;

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < N; i++) pop_d = pop_d + PW'(m_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) pop_q <= '0;
    else     pop_q <= pop_d;
  end

  assign ones_count = pop_q;
`else
  assign ones_count = '0;
`endif

endmodule

// File: tb/tb_rect_flip_engine.sv
// Scoreboard bench for rect_flip_engine: a 4x4 and a 3x5 instance, directed commands with
// hand-computed results queued at accept time and matched by per-instance monitors.
module tb_rect_flip_engine;

  localparam logic [1:0] OP_CORNER = 2'b00, OP_PERIM = 2'b01, OP_FILL = 2'b10, OP_RSVD = 2'b11;

  typedef struct {
    bit          is_err;
    logic [15:0] m;
    int          cyc;
    int          nbusy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t a_q[$];
  exp_t b_q[$];

  // 4x4 instance
  logic        a_load_valid = 1'b0;
  logic [15:0] a_load_data  = '0;
  logic        a_cmd_valid  = 1'b0;
  logic        a_cmd_ready;
  logic [1:0]  a_cmd_op = '0;
  logic [1:0]  a_r1 = '0, a_r2 = '0, a_c1 = '0, a_c2 = '0;
  logic [15:0] a_m_out;
  logic        a_busy, a_done, a_err;
  logic [4:0]  a_ones;

  // 3x5 instance
  logic        b_load_valid = 1'b0;
  logic [14:0] b_load_data  = '0;
  logic        b_cmd_valid  = 1'b0;
  logic        b_cmd_ready;
  logic [1:0]  b_cmd_op = '0;
  logic [1:0]  b_r1 = '0, b_r2 = '0;
  logic [2:0]  b_c1 = '0, b_c2 = '0;
  logic [14:0] b_m_out;
  logic        b_busy, b_done, b_err;
  logic [3:0]  b_ones;

  rect_flip_engine #(.ROWS(4), .COLS(4)) dut_a (
    .clk(clk), .rst(rst), .load_valid(a_load_valid), .load_data(a_load_data),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(a_cmd_op),
    .cmd_r1(a_r1), .cmd_r2(a_r2), .cmd_c1(a_c1), .cmd_c2(a_c2),
    .m_out(a_m_out), .busy(a_busy), .done(a_done), .err(a_err), .ones_count(a_ones)
  );

  rect_flip_engine #(.ROWS(3), .COLS(5)) dut_b (
    .clk(clk), .rst(rst), .load_valid(b_load_valid), .load_data(b_load_data),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
    .cmd_r1(b_r1), .cmd_r2(b_r2), .cmd_c1(b_c1), .cmd_c2(b_c2),
    .m_out(b_m_out), .busy(b_busy), .done(b_done), .err(b_err), .ones_count(b_ones)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected event (cycle %0d)", name, cyc);
  endtask

  // Monitors: pop one expectation per done/err pulse.
  int a_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (a_busy) begin
      a_run++;
      check("a_ready_while_busy", a_cmd_ready, 0);
    end
    if (a_done || a_err) begin
      check("a_done_err_exclusive", a_done & a_err, 0);
      if (a_q.size() == 0) fail_now("a_unexpected_event");
      else begin
        e = a_q.pop_front();
        check("a_event_kind", a_err, e.is_err);
        check("a_event_m_out", a_m_out, e.m);
        check("a_event_cycle", cyc, e.cyc);
        check("a_busy_cycles", a_run, e.nbusy);
      end
    end
    if (!a_busy) a_run = 0;
  end

  int b_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (b_busy) begin
      b_run++;
      check("b_ready_while_busy", b_cmd_ready, 0);
    end
    if (b_done || b_err) begin
      check("b_done_err_exclusive", b_done & b_err, 0);
      if (b_q.size() == 0) fail_now("b_unexpected_event");
      else begin
        e = b_q.pop_front();
        check("b_event_kind", b_err, e.is_err);
        check("b_event_m_out", {1'b0, b_m_out}, e.m);
        check("b_event_cycle", cyc, e.cyc);
        check("b_busy_cycles", b_run, e.nbusy);
      end
    end
    if (!b_busy) b_run = 0;
  end

  // All stimulus tasks are entered and return 1 time unit after a rising edge.
  task automatic issue_a(input logic [1:0] op, input logic [1:0] r1, r2, c1, c2,
                         input bit push, input bit is_err, input logic [15:0] em, input int lat);
    bit acc = 1'b0;
    int tries = 0;
    a_cmd_op = op; a_r1 = r1; a_r2 = r2; a_c1 = c1; a_c2 = c2;
    a_cmd_valid = 1'b1;
    while (!acc && tries < 50) begin
      @(negedge clk); acc = a_cmd_ready;
      @(posedge clk); #1;
      tries++;
    end
    a_cmd_valid = 1'b0;
    if (!acc) fail_now("a_accept_timeout");
    else if (push) a_q.push_back('{is_err, em, cyc + lat, lat});
  endtask

  task automatic issue_b(input logic [1:0] op, input logic [1:0] r1, r2, input logic [2:0] c1, c2,
                         input bit is_err, input logic [14:0] em, input int lat);
    bit acc = 1'b0;
    int tries = 0;
    b_cmd_op = op; b_r1 = r1; b_r2 = r2; b_c1 = c1; b_c2 = c2;
    b_cmd_valid = 1'b1;
    while (!acc && tries < 50) begin
      @(negedge clk); acc = b_cmd_ready;
      @(posedge clk); #1;
      tries++;
    end
    b_cmd_valid = 1'b0;
    if (!acc) fail_now("b_accept_timeout");
    else b_q.push_back('{is_err, {1'b0, em}, cyc + lat, lat});
  endtask

  task automatic wait_idle_a();
    bit idle = 1'b0;
    int tries = 0;
    while (!idle && tries < 50) begin
      @(negedge clk); idle = !a_busy;
      @(posedge clk); #1;
      tries++;
    end
    if (!idle) fail_now("a_idle_timeout");
  endtask

  task automatic wait_idle_b();
    bit idle = 1'b0;
    int tries = 0;
    while (!idle && tries < 50) begin
      @(negedge clk); idle = !b_busy;
      @(posedge clk); #1;
      tries++;
    end
    if (!idle) fail_now("b_idle_timeout");
  endtask

  task automatic load_a(input logic [15:0] d, input logic [15:0] exp_m);
    a_load_valid = 1'b1; a_load_data = d;
    @(posedge clk); #1;
    a_load_valid = 1'b0;
    @(negedge clk); check("a_load_m_out", a_m_out, exp_m);
    @(posedge clk); #1;
  endtask

  task automatic load_b(input logic [14:0] d);
    b_load_valid = 1'b1; b_load_data = d;
    @(posedge clk); #1;
    b_load_valid = 1'b0;
    @(negedge clk); check("b_load_m_out", b_m_out, d);
    @(posedge clk); #1;
  endtask

  initial begin
    int pop_exp;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("a_reset_m_out", a_m_out, 16'h0000);
    check("a_reset_busy", a_busy, 0);
    check("a_reset_done", a_done, 0);
    check("a_reset_err", a_err, 0);
    check("a_reset_ready", a_cmd_ready, 1);
    check("a_reset_ones", a_ones, 0);
    check("b_reset_m_out", b_m_out, 15'h0000);
    @(posedge clk); #1;

    // Single-cycle corner flip.
    issue_a(OP_CORNER, 2'd1, 2'd2, 2'd1, 2'd2, 1, 0, 16'h0660, 0);
    wait_idle_a();

    // Full-border perimeter, with a second command held while busy.
    load_a(16'h0000, 16'h0000);
    issue_a(OP_PERIM, 2'd3, 2'd0, 2'd0, 2'd3, 1, 0, 16'hF99F, 4);
    issue_a(OP_CORNER, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 16'h799F, 0);
    wait_idle_a();

    // Fill over two full rows.
    load_a(16'hFFFF, 16'hFFFF);
    issue_a(OP_FILL, 2'd1, 2'd2, 2'd0, 2'd3, 1, 0, 16'hF00F, 2);
    wait_idle_a();

    // Degenerate rectangles: coincident corners, single-row and single-column perimeters.
    load_a(16'h0000, 16'h0000);
    issue_a(OP_CORNER, 2'd1, 2'd1, 2'd1, 2'd1, 1, 0, 16'h0400, 0);
    wait_idle_a();
    issue_a(OP_PERIM, 2'd1, 2'd1, 2'd1, 2'd2, 1, 0, 16'h0200, 1);
    wait_idle_a();
    issue_a(OP_PERIM, 2'd2, 2'd0, 2'd3, 2'd3, 1, 0, 16'h1310, 3);
    wait_idle_a();

    // Reserved opcode is rejected with the matrix untouched.
    issue_a(OP_RSVD, 2'd0, 2'd1, 2'd0, 2'd1, 1, 1, 16'h1310, 0);
    wait_idle_a();

    // Reset during the second row cycle of a 4-row fill.
    load_a(16'h0000, 16'h0000);
    issue_a(OP_FILL, 2'd0, 2'd3, 2'd0, 2'd3, 0, 0, 16'h0000, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("a_mid_fill_m_out", a_m_out, 16'hF000);
    check("a_mid_fill_busy", a_busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("a_post_rst_m_out", a_m_out, 16'h0000);
    check("a_post_rst_busy", a_busy, 0);
    check("a_post_rst_done", a_done, 0);
    check("a_post_rst_ready", a_cmd_ready, 1);
    @(posedge clk); #1;

    // Popcount trails m_out by one cycle.
`ifdef FLIP_POPCOUNT_EN
    pop_exp = 12;
`else
    pop_exp = 0;
`endif
    a_load_valid = 1'b1; a_load_data = 16'hF99F;
    @(posedge clk); #1;
    a_load_valid = 1'b0;
    @(negedge clk);
    check("a_pop_load_m_out", a_m_out, 16'hF99F);
    check("a_pop_lag", a_ones, 0);
    @(negedge clk);
    check("a_pop_value", a_ones, pop_exp);
    @(posedge clk); #1;

    // 3x5 instance: out-of-range coordinates and reserved opcode.
    load_b(15'h1234);
    issue_b(OP_CORNER, 2'd3, 2'd0, 3'd0, 3'd0, 1, 15'h1234, 0);
    wait_idle_b();
    issue_b(OP_RSVD, 2'd1, 2'd0, 3'd1, 3'd0, 1, 15'h1234, 0);
    wait_idle_b();
    issue_b(OP_FILL, 2'd0, 2'd0, 3'd5, 3'd0, 1, 15'h1234, 0);
    wait_idle_b();

    // Load and command together: load wins, command taken the next cycle.
    b_load_valid = 1'b1; b_load_data = 15'h0000;
    b_cmd_valid = 1'b1; b_cmd_op = OP_CORNER;
    b_r1 = 2'd2; b_r2 = 2'd0; b_c1 = 3'd4; b_c2 = 3'd0;
    @(negedge clk);
    check("b_ready_during_load", b_cmd_ready, 0);
    @(posedge clk); #1;
    b_load_valid = 1'b0;
    b_q.push_back('{1'b0, 16'h4411, cyc + 1, 0});
    @(negedge clk);
    check("b_load_won_m_out", b_m_out, 15'h0000);
    check("b_ready_after_load", b_cmd_ready, 1);
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    wait_idle_b();

    // Multi-row fill on the non-square matrix.
    issue_b(OP_FILL, 2'd2, 2'd0, 3'd1, 3'd3, 0, 15'h7DDF, 3);
    wait_idle_b();

    repeat (3) @(posedge clk);
    check("a_queue_drained", a_q.size(), 0);
    check("b_queue_drained", b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
